opensync_cf_update: RTL
=======================

OPENSYNC_CF_UPDATE -- requirements
Module: opensync_cf_update

Interface
REQ-001 Parameter CF_OFFSET, default 22: byte index of the first (MSB) correction-field byte within the frame (14-byte Ethernet header + 8).
REQ-002 Parameter PTP_ETYPE, default 16'h88F7: EtherType that qualifies a frame for update.
REQ-003 i_clk  input  1  clock; all logic on the rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 iv_data  input  8  decapsulated frame byte, byte 0 first.
REQ-006 i_data_wr  input  1  byte valid; high for contiguous cycles per frame, at least one low cycle between frames.
REQ-007 iv_receive_time  input  64  receive timestamp in ns; sampled only while i_cf_update_flag is high.
REQ-008 i_cf_update_flag  input  1  single-cycle pulse that arms an update for the next frame to start.
REQ-009 iv_local_time  input  64  free-running local time in ns.
REQ-010 ov_data  output  8  frame byte, possibly with correction field rewritten.
REQ-011 o_data_wr  output  1  output byte valid.

Function
REQ-012 The block SHALL delay every input byte and its valid through an 8-stage shift line, so each byte appears on ov_data/o_data_wr exactly 8 cycles after it is accepted, frame shape (length, gaps) unchanged.
REQ-013 The block SHALL keep an 11-bit byte index: reset to 0 on every cycle with i_data_wr low, increment per accepted byte, saturate at 2047.
REQ-014 On an i_cf_update_flag pulse the block SHALL latch iv_receive_time and set an armed flag; a pulse during an active input frame arms the next frame, not the current one.
REQ-015 A second pulse while armed SHALL overwrite the latched receive time (last pulse wins).
REQ-016 States: IDLE (not armed), ARMED (waiting for frame start), CHECK (armed frame, bytes 0..13), UPDATE (qualified, collecting CF), PASS (forward unmodified).
REQ-017 IDLE->ARMED on pulse; ARMED->CHECK on first byte, capturing iv_local_time in the same cycle; IDLE->PASS on a frame start while not armed.
REQ-018 In CHECK, bytes 12..13 SHALL be compared to PTP_ETYPE; match -> UPDATE, mismatch -> PASS; the armed flag SHALL clear on entry to CHECK in both cases.
REQ-019 Residence time SHALL be (captured local time - latched receive time) mod 2^64, computed once before byte CF_OFFSET arrives.
REQ-020 In UPDATE, when byte CF_OFFSET+7 is accepted, the 8 CF bytes (big-endian) SHALL be replaced in the shift line by (CF_old + (residence << 16)) mod 2^64, most-significant byte at index CF_OFFSET.
REQ-021 All non-CF bytes SHALL pass unmodified; no other field (e.g. FCS) is altered.
REQ-022 A qualified frame ending before byte CF_OFFSET+7 SHALL be forwarded unmodified and the block SHALL return to IDLE.
REQ-023 Any state SHALL return to IDLE (or ARMED if a pulse arrived meanwhile) on the cycle i_data_wr falls; the shift line continues draining independently.
REQ-024 A pulse coinciding with the first byte of a frame SHALL arm the following frame.

Reset
REQ-025 While i_rst_n is low: ov_data=0, o_data_wr=0, shift line data/valid=0, byte index=0, latched times=0, armed=0, state=IDLE.
REQ-026 Reset asserted mid-frame SHALL discard all buffered bytes; the first frame start after release is processed as unarmed.

Verification
REQ-027 60-byte frame, no pulse -> identical 60 bytes out, o_data_wr high 60 cycles, starting 8 cycles after input start.
REQ-028 Pulse with receive_time=1000, local_time=1500 at byte 0, EtherType 88F7, CF=0x0000_0000_0001_0000 -> output CF=0x0000_0000_01F5_0000, all other bytes unchanged.
REQ-029 Same as REQ-028 but EtherType 0800 -> frame unmodified; armed flag cleared, next 88F7 frame also unmodified.
REQ-030 Armed 88F7 frame of 26 bytes -> forwarded unmodified, state IDLE after end.
REQ-031 CF=0xFFFF_FFFF_FFFF_0000, residence 1 ns -> output CF=0x0000_0000_0000_0000 (wrap).
REQ-032 i_rst_n low at byte 30 of an armed frame -> o_data_wr low immediately, no output bytes until next input frame, which is unmodified.

Source files
------------

// File: rtl/opensync_cf_update.sv
// PTP transparent-clock correction-field updater: delays the byte stream by eight
// cycles and, for an armed PTP frame, adds the residence time into the correction field.
module opensync_cf_update #(
    parameter int unsigned CF_OFFSET = 22,
    parameter logic [15:0] PTP_ETYPE = 16'h88F7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  iv_data,
    input  logic        i_data_wr,
    input  logic [63:0] iv_receive_time,
    input  logic        i_cf_update_flag,
    input  logic [63:0] iv_local_time,
    output logic [7:0]  ov_data,
    output logic        o_data_wr
);

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned IDX_W  = 11;
    localparam int unsigned RES_W  = 48;
    localparam logic [IDX_W-1:0] IDX_MAX    = IDX_W'(2047);
    localparam logic [IDX_W-1:0] IDX_ET_HI  = IDX_W'(12);
    localparam logic [IDX_W-1:0] IDX_ET_LO  = IDX_W'(13);
    localparam logic [IDX_W-1:0] IDX_CF_END = IDX_W'(CF_OFFSET + 7);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        CHECK,
        UPDATE,
        PASS
    } state_t;

    state_t             state_q, state_d;
    logic               armed_q, armed_d;
    logic [63:0]        rx_time_q;
    logic [RES_W-1:0]   res_q;
    logic [IDX_W-1:0]   byte_idx_q;
    logic [7:0]         sd_data [DEPTH];
    logic               sd_valid [DEPTH];

    logic               capture_c;
    logic               rewrite_c;
    logic [63:0]        cf_old_c;
    logic [63:0]        cf_new_c;

    // Correction field as it stands the cycle its last byte is accepted: seven bytes
    // already in the line plus the incoming one.
    assign cf_old_c = {sd_data[6], sd_data[5], sd_data[4], sd_data[3],
                       sd_data[2], sd_data[1], sd_data[0], iv_data};
    assign cf_new_c = cf_old_c + {res_q, 16'h0000};

    assign ov_data   = sd_data[DEPTH-1];
    assign o_data_wr = sd_valid[DEPTH-1];

    // Eight-stage delay line; on rewrite the whole CF lands in stages 7..0 at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                sd_data[i]  <= 8'h00;
                sd_valid[i] <= 1'b0;
            end
        end else begin
            sd_data[0]  <= i_data_wr ? iv_data : 8'h00;
            sd_valid[0] <= i_data_wr;
            for (int i = 1; i < DEPTH; i++) begin
                sd_data[i]  <= sd_data[i-1];
                sd_valid[i] <= sd_valid[i-1];
            end
            if (rewrite_c) begin
                for (int i = 0; i < DEPTH; i++) begin
                    sd_data[i] <= cf_new_c[8*i +: 8];
                end
            end
        end
    end

    // Byte index within the current frame, cleared in every gap cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx_q <= '0;
        end else if (!i_data_wr) begin
            byte_idx_q <= '0;
        end else if (byte_idx_q != IDX_MAX) begin
            byte_idx_q <= byte_idx_q + IDX_W'(1);
        end
    end

    // Receive time from the latest pulse; residence fixed at the armed frame's first byte.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_time_q <= '0;
            res_q     <= '0;
        end else begin
            if (capture_c) begin
                res_q <= RES_W'(iv_local_time - rx_time_q);
            end
            if (i_cf_update_flag) begin
                rx_time_q <= iv_receive_time;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            armed_q <= armed_d;
        end
    end

    // Next-state logic; a pulse always re-arms, even on the cycle an armed frame starts.
    always_comb begin
        state_d   = state_q;
        armed_d   = armed_q;
        capture_c = 1'b0;
        rewrite_c = 1'b0;

        if (!i_data_wr) begin
            state_d = (armed_q || i_cf_update_flag) ? ARMED : IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = PASS;
                end
                ARMED: begin
                    state_d   = CHECK;
                    capture_c = 1'b1;
                    armed_d   = 1'b0;
                end
                CHECK: begin
                    if (byte_idx_q == IDX_ET_HI && iv_data != PTP_ETYPE[15:8]) begin
                        state_d = PASS;
                    end else if (byte_idx_q == IDX_ET_LO) begin
                        state_d = (iv_data == PTP_ETYPE[7:0]) ? UPDATE : PASS;
                    end
                end
                UPDATE: begin
                    if (byte_idx_q == IDX_CF_END) begin
                        rewrite_c = 1'b1;
                        state_d   = PASS;
                    end
                end
                PASS: begin
                    state_d = PASS;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (i_cf_update_flag) begin
            armed_d = 1'b1;
        end
    end

endmodule
